// File: rtl/sat_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sat_pkg
// Description : Shared types for the DPLL solver datapath. Holds the
//               backtrack FSM state encoding, the trace stack constants and
//               the trace stack entry layout used by the trace table and by
//               backtrack_unit.
// Revision    : 1.0 - initial release
// ============================================================================
package sat_pkg;

    // Width of the variable field in a trace entry (VARIABLE_INDEXES + 1).
    localparam int unsigned TRACE_VAR_W = 9;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CHECK = 3'd1,
        EVAL  = 3'd2,
        PUSH  = 3'd3,
        DONE  = 3'd4
    } bt_state_t;

    localparam logic TRACE_DECIDE = 1'b0;
    localparam logic TRACE_FORCED = 1'b1;
    localparam logic TRACE_POP    = 1'b0;
    localparam logic TRACE_PUSH   = 1'b1;

    // "type" is a reserved word, so the type field is named entry_type.
    typedef struct packed {
        logic                   entry_type;
        logic                   val;
        logic [TRACE_VAR_W-1:0] variable;
    } trace_entry_t;

    // Turns a popped decision into the entry pushed back after the flip:
    // a decision (0) comes back as forced (1) with the opposite value.
    function automatic trace_entry_t flip_entry(input trace_entry_t e);
        trace_entry_t f;
        f.entry_type = ~e.entry_type;
        f.val        = ~e.val;
        f.variable   = e.variable;
        return f;
    endfunction

endpackage
`default_nettype wire

// File: rtl/backtrack_unit.sv
`default_nettype none
// ============================================================================
// Module      : backtrack_unit
// Description : Conflict-side consumer of the DPLL trace stack. Pops entries
//               and unassigns their variables until the most recent decision
//               is found, then pushes that decision back as a forced entry
//               with the opposite value and reports the flipped literal. A
//               stack that drains without a decision reports UNSAT.
// Ports       : clk, reset (async, active-high)
//               start / busy / done / unsat    - control and status
//               flip_var / flip_val / depth    - backtrack result
//               trace_en, trace_rw, trace_*    - trace stack access port
//               trace_*_out, trace_empty       - trace stack pop data
//               var_we, var_idx, var_assigned,
//               var_value                      - variable-state write port
// Revision    : 1.0 - initial release
// ============================================================================
module backtrack_unit
    import sat_pkg::*;
#(
    parameter int NUM_VARIABLE     = 128,
    parameter int VARIABLE_INDEXES = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    output logic                        busy,
    output logic                        done,
    output logic                        unsat,
    output logic [VARIABLE_INDEXES:0]   flip_var,
    output logic                        flip_val,
    output logic [VARIABLE_INDEXES:0]   depth,
    output logic                        trace_en,
    output logic                        trace_rw,
    output logic                        trace_type,
    output logic                        trace_val,
    output logic [VARIABLE_INDEXES:0]   trace_variable,
    input  logic                        trace_type_out,
    input  logic                        trace_val_out,
    input  logic [VARIABLE_INDEXES:0]   trace_variable_out,
    input  logic                        trace_empty,
    output logic                        var_we,
    output logic [VARIABLE_INDEXES:0]   var_idx,
    output logic                        var_assigned,
    output logic                        var_value
);

    localparam int VW = VARIABLE_INDEXES + 1;

    // The entry layout is fixed by the package; refuse to elaborate with a
    // variable index width that would not fit it.
    generate
        if ((VW != TRACE_VAR_W) || (NUM_VARIABLE > (1 << VW))) begin : g_param_guard
            $error("backtrack_unit: parameters do not match trace_entry_t");
        end
    endgenerate

    bt_state_t      r_state;
    trace_entry_t   r_entry;
    logic [VW-1:0]  r_depth;
    logic           r_unsat;
    logic [VW-1:0]  r_flip_var;
    logic           r_flip_val;
    trace_entry_t   w_push_entry;

    // ------------------------------------------------------------------------
    // Control FSM, popped-entry latch, depth counter and result registers.
    // Result registers are cleared when a start is accepted so the previous
    // result stays visible after done until the next backtrack begins.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_entry    <= '0;
            r_depth    <= '0;
            r_unsat    <= 1'b0;
            r_flip_var <= '0;
            r_flip_val <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_depth    <= '0;
                        r_unsat    <= 1'b0;
                        r_flip_var <= '0;
                        r_flip_val <= 1'b0;
                        r_state    <= CHECK;
                    end
                end
                CHECK: begin
                    if (trace_empty) begin
                        r_unsat <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        // Saturate rather than wrap on very deep backtracks.
                        if (r_depth != '1) begin
                            r_depth <= r_depth + VW'(1);
                        end
                        r_state <= EVAL;
                    end
                end
                EVAL: begin
                    r_entry.entry_type <= trace_type_out;
                    r_entry.val        <= trace_val_out;
                    r_entry.variable   <= trace_variable_out;
                    r_state            <= (trace_type_out == TRACE_FORCED) ? CHECK : PUSH;
                end
                PUSH: begin
                    r_flip_var <= w_push_entry.variable;
                    r_flip_val <= w_push_entry.val;
                    r_state    <= DONE;
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign unsat    = r_unsat;
    assign flip_var = r_flip_var;
    assign flip_val = r_flip_val;
    assign depth    = r_depth;

    // ------------------------------------------------------------------------
    // Strobes decoded from the state register. The pop in CHECK depends on
    // trace_empty in the same cycle, so it cannot be decided a cycle early.
    // ------------------------------------------------------------------------
    always_comb begin
        w_push_entry   = flip_entry(r_entry);
        busy           = (r_state != IDLE);
        done           = (r_state == DONE);
        trace_en       = 1'b0;
        trace_rw       = TRACE_POP;
        trace_type     = 1'b0;
        trace_val      = 1'b0;
        trace_variable = '0;
        var_we         = 1'b0;
        var_idx        = '0;
        var_assigned   = 1'b0;
        var_value      = 1'b0;
        case (r_state)
            CHECK: begin
                trace_en = ~trace_empty;
            end
            EVAL: begin
                // Pop data arrives this cycle; unassign it straight away.
                var_we  = 1'b1;
                var_idx = trace_variable_out;
            end
            PUSH: begin
                trace_en       = 1'b1;
                trace_rw       = TRACE_PUSH;
                trace_type     = w_push_entry.entry_type;
                trace_val      = w_push_entry.val;
                trace_variable = w_push_entry.variable;
                var_we         = 1'b1;
                var_idx        = w_push_entry.variable;
                var_assigned   = 1'b1;
                var_value      = w_push_entry.val;
            end
            default: begin
            end
        endcase
    end

endmodule
`default_nettype wire

// File: doc/backtrack_unit.md
# backtrack_unit

- Reader/consumer side of the DPLL trace stack, used on conflict.
- Pops trace entries and clears their variable assignments until it reaches the most recent decision.
- Flips that decision and pushes it back as a forced assignment, then hands the flipped literal to propagation.
- If the stack drains without finding a decision, it reports UNSAT.

## Interface
Parameters:
- NUM_VARIABLE, 128, number of solver variables
- VARIABLE_INDEXES, 8, variable index is VARIABLE_INDEXES+1 bits wide

Ports:
- clk  in  1  clock; all state on rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  conflict detected; begin backtrack (sampled in IDLE only)
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at end of backtrack
- unsat  out  1  valid with done; held until next accepted start
- flip_var  out  VARIABLE_INDEXES+1  flipped variable; valid with done when unsat=0, held until next start
- flip_val  out  1  new value of flip_var
- depth  out  VARIABLE_INDEXES+1  entries popped this backtrack; saturates at all-ones
- trace_en  out  1  trace table access strobe
- trace_rw  out  1  0 = pop, 1 = push
- trace_type  out  1  push type (0 = decided, 1 = forced)
- trace_val  out  1  push value
- trace_variable  out  VARIABLE_INDEXES+1  push variable
- trace_type_out  in  1  popped type
- trace_val_out  in  1  popped value
- trace_variable_out  in  VARIABLE_INDEXES+1  popped variable
- trace_empty  in  1  stack empty
- var_we  out  1  variable-state memory write strobe
- var_idx  out  VARIABLE_INDEXES+1  variable written
- var_assigned  out  1  0 = unassign, 1 = assign
- var_value  out  1  value written when var_assigned=1

## Operation
States: IDLE, CHECK, EVAL, PUSH, DONE.

- **IDLE**
  - start=1 → CHECK.
  - Clears depth, unsat, flip_var and flip_val.
- **CHECK**
  - trace_empty=1 → DONE with unsat set; no pop is issued.
  - Otherwise drive trace_en=1, trace_rw=0 (pop) and increment depth → EVAL.
- **EVAL**
  - Popped entry is valid on trace_*_out this cycle; latch it.
  - Drive var_we=1, var_idx=popped variable, var_assigned=0.
  - Popped type=1 (forced) → CHECK.
  - Popped type=0 (decided) → PUSH.
- **PUSH**
  - Drive trace_en=1, trace_rw=1, trace_type=1, trace_val=~latched val, trace_variable=latched variable.
  - Same cycle: drive var_we=1, var_assigned=1, var_value=~latched val.
  - Load flip_var and flip_val → DONE.
- **DONE**
  - Drive done=1 → IDLE.

Strobe rules:
- trace_en, var_we and done are high only in the states listed above; low in every other cycle.
- trace push data fields are 0 when not pushing.

Boundaries:
- start while busy is ignored.
- Stack empty at start → UNSAT, depth=0.
- A decision entry at the bottom of the stack is flipped normally.
- depth saturates instead of wrapping.
- Entries with type=1 are never flipped.

## Timing
- Start accepted at cycle 0. With k entries popped (last one a decision), done is high at cycle 2k+2.
- UNSAT after k forced pops: CHECK sees empty at cycle 2k+1, done at cycle 2k+2.
- Exactly one trace access per CHECK-with-pop and per PUSH cycle; never two in one cycle.
- Trace table pop data is valid the cycle after the pop strobe.
- Reset (asynchronous, any state):
  - State goes to IDLE.
  - All outputs go to 0: busy, done, unsat, flip_var, flip_val, depth and all trace_* and var_* outputs.
  - A backtrack in flight is abandoned; trace table and variable memory are reset by the same reset.

## Structure
- Shared package sat_pkg holds:
  - Enum bt_state_t {IDLE, CHECK, EVAL, PUSH, DONE}.
  - Constants TRACE_DECIDE=1'b0, TRACE_FORCED=1'b1, TRACE_POP=1'b0, TRACE_PUSH=1'b1.
  - Packed struct trace_entry_t {type, val, variable}, used by the trace table and this block.
- No sub-module: one FSM plus an entry latch and the depth counter.

## Test plan
- **Single decision:** stack holds {0,1,5}; start → pop at cycle 1, var 5 unassigned at cycle 2, push {1,0,5} at cycle 3, done at cycle 4 with unsat=0, flip_var=5, flip_val=0, depth=1.
- **Forced entries above a decision:** stack bottom→top {0,0,3},{1,1,7},{1,0,9}; start → unassign 9 then 7 then 3, push {1,1,3}, done at cycle 8, depth=3.
- **Empty at start:** trace_empty=1; start → no trace_en, done at cycle 2, unsat=1, depth=0.
- **Only forced entries:** stack {1,1,2},{1,0,4} → both unassigned, no push, done at cycle 6, unsat=1.
- **Mid-operation reset, then start while busy:**
  - Assert reset during EVAL → all outputs 0 that cycle, returns to IDLE.
  - Then pulse start twice in a row → only one backtrack runs; the second start is ignored.
